calc_sequencer: RTL and testbench

Multi-cycle control FSM for the calculator datapath: fetch, decode and execute of a ROM-resident RV32I-style ALU program. Drives ROM address, register-file read/write addresses, ALU control and immediate select. Shares the register file's second read port between the program and a host read interface. Sits between the instruction ROM, `registerfile` and `alu`, and replaces the free-running instruction counter.

---
 rtl/calc_pkg.sv | 41 ++++
 rtl/calc_sequencer_if.sv | 30 +++
 rtl/calc_decoder.sv | 47 ++++
 rtl/calc_sequencer.sv | 155 +++++++++++++++
 tb/tb_calc_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared types and encodings for the calculator sequencer: FSM states, RV32I opcode/funct3
// subsets, ALU operation codes and the decoded-control bundle carried from EXEC into WB.
package calc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_WB,
        ST_PAUSE,
        ST_DONE
    } state_t;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    typedef struct packed {
        logic [3:0] alu_ctl;
        logic       imm_sel;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } ctl_t;

    function automatic logic is_addsub(input logic [3:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Datapath-side bus of the sequencer: ROM fetch, register-file addressing, ALU control and
// the host read port that shares register-file read port 2. Master = sequencer.
interface calc_sequencer_if #(
    parameter int W    = 32,
    parameter int PC_W = 4
);
    logic [PC_W-1:0] rom_addr;
    logic [31:0]     rom_data;
    logic [4:0]      rf_read1;
    logic [4:0]      rf_read2;
    logic [4:0]      rf_waddr;
    logic            rf_we;
    logic [3:0]      alu_ctl;
    logic            imm_sel;
    logic [W-1:0]    imm;
    logic            alu_ovf;
    logic            host_req;
    logic [4:0]      host_addr;
    logic            host_ack;

    modport master (
        output rom_addr, rf_read1, rf_read2, rf_waddr, rf_we, alu_ctl, imm_sel, imm, host_ack,
        input  rom_data, alu_ovf, host_req, host_addr
    );

    modport slave (
        input  rom_addr, rf_read1, rf_read2, rf_waddr, rf_we, alu_ctl, imm_sel, imm, host_ack,
        output rom_data, alu_ovf, host_req, host_addr
    );
endinterface

// File: rtl/calc_decoder.sv
// Combinational instruction decoder: 32-bit word to ALU control, operand select, sign-extended
// immediate and register addresses. Zero latency; flags the all-zero end marker and illegal words.
module calc_decoder
    import calc_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [31:0]  instr,
    output ctl_t         ctl,
    output logic [W-1:0] imm,
    output logic         is_end,
    output logic         illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_r;
    logic       is_i;
    logic       bad_f3;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign is_r   = (opcode == OP_R);
    assign is_i   = (opcode == OP_I);

    always_comb begin
        ctl.rs1     = instr[19:15];
        ctl.rs2     = instr[24:20];
        ctl.rd      = instr[11:7];
        ctl.imm_sel = is_i;
        ctl.alu_ctl = ALU_AND;
        bad_f3      = 1'b0;
        case (funct3)
            // bit30 only selects SUB for register-register; addi ignores it
            F3_ADD:  ctl.alu_ctl = (is_r && instr[30]) ? ALU_SUB : ALU_ADD;
            F3_SLT:  ctl.alu_ctl = ALU_SLT;
            F3_OR:   ctl.alu_ctl = ALU_OR;
            F3_AND:  ctl.alu_ctl = ALU_AND;
            default: bad_f3      = 1'b1;
        endcase
    end

    assign imm     = {{(W-12){instr[31]}}, instr[31:20]};
    assign is_end  = (instr == 32'h0000_0000);
    assign illegal = !is_end && (bad_f3 || !(is_r || is_i));

endmodule

// File: rtl/calc_sequencer.sv
// Fetch/decode/execute control FSM for the calculator datapath; 3 cycles per instruction.
// Register-file read port 2 is lent to the host outside EXEC/WB; a host request waits at most 2 cycles.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int W    = 32,
    parameter int PC_W = 4,
    parameter int LEN  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    calc_sequencer_if.master bus,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             ovf_sticky,
    output logic [PC_W-1:0]  pc
);

    localparam logic [PC_W-1:0] PC_LAST = PC_W'(LEN - 1);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            err_q, err_d;
    logic            ovf_q, ovf_d;
    ctl_t            ctl_q, ctl_d;
    logic [W-1:0]    imm_q, imm_d;

    ctl_t            dec_ctl;
    logic [W-1:0]    dec_imm;
    logic            dec_end;
    logic            dec_illegal;

    calc_decoder #(.W(W)) u_decoder (
        .instr   (bus.rom_data),
        .ctl     (dec_ctl),
        .imm     (dec_imm),
        .is_end  (dec_end),
        .illegal (dec_illegal)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        ctl_d   = ctl_q;
        imm_d   = imm_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                    err_d   = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                if (dec_end) begin
                    state_d = ST_DONE;
                end else if (dec_illegal) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    ctl_d   = dec_ctl;
                    imm_d   = dec_imm;
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                if (is_addsub(ctl_q.alu_ctl) && bus.alu_ovf) begin
                    ovf_d = 1'b1;
                end
                // last slot: pc stays put so it never wraps past the program end
                if (pc_q == PC_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    pc_d    = pc_q + PC_W'(1);
                    state_d = step_mode ? ST_PAUSE : ST_FETCH;
                end
            end
            ST_PAUSE: begin
                if (step || !step_mode) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            ctl_q   <= '0;
            imm_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            ctl_q   <= ctl_d;
            imm_q   <= imm_d;
        end
    end

    // Datapath outputs: live decode in EXEC, held copy in WB, host owns port 2 otherwise.
    always_comb begin
        bus.rf_read1 = '0;
        bus.rf_read2 = bus.host_addr;
        bus.rf_waddr = '0;
        bus.rf_we    = 1'b0;
        bus.alu_ctl  = ALU_AND;
        bus.imm_sel  = 1'b0;
        bus.imm      = '0;
        bus.host_ack = bus.host_req;
        case (state_q)
            ST_EXEC: begin
                bus.rf_read1 = dec_ctl.rs1;
                bus.rf_read2 = dec_ctl.rs2;
                bus.rf_waddr = dec_ctl.rd;
                bus.alu_ctl  = dec_ctl.alu_ctl;
                bus.imm_sel  = dec_ctl.imm_sel;
                bus.imm      = dec_imm;
                bus.host_ack = 1'b0;
            end
            ST_WB: begin
                bus.rf_read1 = ctl_q.rs1;
                bus.rf_read2 = ctl_q.rs2;
                bus.rf_waddr = ctl_q.rd;
                bus.rf_we    = (ctl_q.rd != 5'd0) && !reset;
                bus.alu_ctl  = ctl_q.alu_ctl;
                bus.imm_sel  = ctl_q.imm_sel;
                bus.imm      = imm_q;
                bus.host_ack = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.rom_addr = pc_q;
    assign pc           = pc_q;
    assign err          = err_q;
    assign ovf_sticky   = ovf_q;
    assign done         = (state_q == ST_DONE);
    assign busy         = (state_q == ST_FETCH) || (state_q == ST_EXEC) ||
                          (state_q == ST_WB)    || (state_q == ST_PAUSE);

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a synchronous ROM, register file and ALU around it.
module tb_calc_sequencer;
    import calc_pkg::*;

    localparam int W    = 32;
    localparam int PC_W = 4;
    localparam int LEN  = 16;

    logic            clock = 1'b0;
    logic            reset;
    logic            start;
    logic            step_mode;
    logic            step;
    logic            busy;
    logic            done;
    logic            err;
    logic            ovf_sticky;
    logic [PC_W-1:0] pc;

    int checks = 0;
    int errors = 0;

    calc_sequencer_if #(.W(W), .PC_W(PC_W)) bus ();

    calc_sequencer #(.W(W), .PC_W(PC_W), .LEN(LEN)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .step_mode  (step_mode),
        .step       (step),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .ovf_sticky (ovf_sticky),
        .pc         (pc)
    );

    always #5 clock = ~clock;

    // Environment: synchronous ROM, 2R1W register file, ALU
    logic [31:0] rom [LEN];
    logic [31:0] rf  [32];
    logic        rf_clr;
    logic        pre_we;
    logic [4:0]  pre_addr;
    logic [31:0] pre_val;
    logic [31:0] data1, data2, alu_b, alu_res;
    logic        alu_ovf;

    always @(posedge clock) bus.rom_data <= rom[bus.rom_addr];

    always @(posedge clock) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            if (pre_we) rf[pre_addr] <= pre_val;
            if (bus.rf_we) rf[bus.rf_waddr] <= alu_res;
        end
    end

    assign data1 = (bus.rf_read1 == 5'd0) ? 32'd0 : rf[bus.rf_read1];
    assign data2 = (bus.rf_read2 == 5'd0) ? 32'd0 : rf[bus.rf_read2];

    always_comb begin
        alu_b   = bus.imm_sel ? bus.imm : data2;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.alu_ctl)
            4'd0: alu_res = data1 & alu_b;
            4'd1: alu_res = data1 | alu_b;
            4'd2: begin
                alu_res = data1 + alu_b;
                alu_ovf = (data1[31] == alu_b[31]) && (alu_res[31] != data1[31]);
            end
            4'd6: begin
                alu_res = data1 - alu_b;
                alu_ovf = (data1[31] != alu_b[31]) && (alu_res[31] != data1[31]);
            end
            4'd7:  alu_res = {31'd0, ($signed(data1) < $signed(alu_b))};
            4'd12: alu_res = ~(data1 | alu_b);
            default: alu_res = '0;
        endcase
    end
    assign bus.alu_ovf = alu_ovf;

    task automatic clear_rf();
        @(negedge clock); rf_clr = 1'b1;
        @(negedge clock); rf_clr = 1'b0;
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] v);
        @(negedge clock); pre_we = 1'b1; pre_addr = a; pre_val = v;
        @(negedge clock); pre_we = 1'b0;
    endtask

    task automatic load_demo();
        for (int i = 0; i < LEN; i++) rom[i] = 32'h0;
        rom[0] = 32'h00500093;  // addi x1,x0,5
        rom[1] = 32'h00700113;  // addi x2,x0,7
        rom[2] = 32'h002081B3;  // add  x3,x1,x2
        rom[3] = 32'h40208233;  // sub  x4,x1,x2
        rom[4] = 32'h0020A2B3;  // slt  x5,x1,x2
    endtask

    // Returns at the falling edge inside cycle 1 (FETCH of instruction 0)
    task automatic pulse_start();
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1; start = 1'b0; step_mode = 1'b0; step = 1'b0;
        bus.host_req = 1'b0; bus.host_addr = 5'd0;
        @(negedge clock); @(negedge clock);
        reset = 1'b0;
        checks++;
        if ({busy, done, err, ovf_sticky} !== 4'b0000) begin
            errors++; $display("FAIL reset_status: got %b expected 0000", {busy, done, err, ovf_sticky});
        end
        checks++;
        if ({pc, bus.rom_addr, bus.rf_read1, bus.rf_read2, bus.rf_waddr, bus.rf_we} !== '0) begin
            errors++; $display("FAIL reset_addr: pc=%0d rom=%0d r1=%0d r2=%0d wa=%0d we=%b expected all 0",
                               pc, bus.rom_addr, bus.rf_read1, bus.rf_read2, bus.rf_waddr, bus.rf_we);
        end
        checks++;
        if ({bus.alu_ctl, bus.imm_sel, bus.imm, bus.host_ack} !== '0) begin
            errors++; $display("FAIL reset_ctl: alu=%0d isel=%b imm=%0h ack=%b expected all 0",
                               bus.alu_ctl, bus.imm_sel, bus.imm, bus.host_ack);
        end
        bus.host_req = 1'b1; bus.host_addr = 5'd5;
        #1;
        checks++;
        if ({bus.host_ack, bus.rf_read2} !== {1'b1, 5'd5}) begin
            errors++; $display("FAIL idle_host: ack=%b r2=%0d expected ack=1 r2=5", bus.host_ack, bus.rf_read2);
        end
        bus.host_req = 1'b0; bus.host_addr = 5'd0;
        clear_rf();
    endtask

    task automatic test_program();
        int done_cyc = -1;
        clear_rf();
        load_demo();
        pulse_start();
        for (int c = 1; c <= 22; c++) begin
            if (c > 1) @(negedge clock);
            if (done && done_cyc < 0) done_cyc = c;
            if (c == 4) begin
                checks++;
                if (pc !== 4'd1) begin errors++; $display("FAIL prog_pc4: got %0d expected 1", pc); end
            end
            if (c == 18) begin
                checks++;
                if ({busy, done} !== 2'b01) begin
                    errors++; $display("FAIL prog_done_busy: busy=%b done=%b expected 0 1", busy, done);
                end
            end
            start = (c == 5);  // start while busy must be ignored
        end
        checks++;
        if (done_cyc != 18) begin errors++; $display("FAIL prog_done_cycle: got %0d expected 18", done_cyc); end
        checks++;
        if ({rf[1], rf[2], rf[3]} !== {32'd5, 32'd7, 32'd12}) begin
            errors++; $display("FAIL prog_x1_x3: got %0h %0h %0h expected 5 7 c", rf[1], rf[2], rf[3]);
        end
        checks++;
        if ({rf[4], rf[5]} !== {32'hFFFFFFFE, 32'd1}) begin
            errors++; $display("FAIL prog_x4_x5: got %0h %0h expected fffffffe 1", rf[4], rf[5]);
        end
    endtask

    task automatic test_illegal();
        int done_cyc = -1;
        int we_seen  = 0;
        clear_rf();
        rom[0] = 32'h00001033;
        pulse_start();
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) @(negedge clock);
            if (bus.rf_we) we_seen++;
            if (done && done_cyc < 0) done_cyc = c;
        end
        checks++;
        if (done_cyc != 3) begin errors++; $display("FAIL illegal_done_cycle: got %0d expected 3", done_cyc); end
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b expected 1", err); end
        checks++;
        if (we_seen != 0) begin errors++; $display("FAIL illegal_no_write: got %0d we cycles expected 0", we_seen); end
    endtask

    task automatic test_host();
        logic exp_ack;
        clear_rf();
        load_demo();
        bus.host_req = 1'b1; bus.host_addr = 5'd3;
        pulse_start();
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clock);
            if (c == 1) begin
                checks++;
                if (err !== 1'b0) begin errors++; $display("FAIL host_err_cleared: got %b expected 0", err); end
            end
            exp_ack = (c >= 18) || (c % 3 == 1);
            checks++;
            if (bus.host_ack !== exp_ack) begin
                errors++; $display("FAIL host_ack c%0d: got %b expected %b", c, bus.host_ack, exp_ack);
            end
            if (exp_ack) begin
                checks++;
                if (data2 !== ((c >= 10) ? 32'd12 : 32'd0)) begin
                    errors++; $display("FAIL host_data c%0d: got %0h expected %0h", c, data2, (c >= 10) ? 12 : 0);
                end
            end
        end
        bus.host_req = 1'b0; bus.host_addr = 5'd0;
    endtask

    task automatic test_step();
        int done_cyc = -1;
        clear_rf();
        load_demo();
        step_mode = 1'b1;
        pulse_start();
        for (int c = 1; c <= 30; c++) begin
            if (c > 1) @(negedge clock);
            if (c == 4 || c == 7 || c == 8 || c == 10) begin
                checks++;
                if (pc !== 4'd1) begin errors++; $display("FAIL step_pc1 c%0d: got %0d expected 1", c, pc); end
            end
            if (c == 7 || c == 12) begin
                checks++;
                if ({busy, done} !== 2'b10) begin
                    errors++; $display("FAIL step_pause c%0d: busy=%b done=%b expected 1 0", c, busy, done);
                end
            end
            if (c == 11 || c == 13) begin
                checks++;
                if (pc !== 4'd2) begin errors++; $display("FAIL step_pc2 c%0d: got %0d expected 2", c, pc); end
            end
            if (done && done_cyc < 0) done_cyc = c;
            step = (c >= 7 && c <= 9);  // one real step in PAUSE, then strays in FETCH/EXEC
            if (c == 13) step_mode = 1'b0;
        end
        checks++;
        if (done_cyc != 25) begin errors++; $display("FAIL step_done_cycle: got %0d expected 25", done_cyc); end
        checks++;
        if ({rf[3], rf[5]} !== {32'd12, 32'd1}) begin
            errors++; $display("FAIL step_regs: got %0h %0h expected c 1", rf[3], rf[5]);
        end
    endtask

    task automatic test_overflow();
        clear_rf();
        preload(5'd1, 32'h7FFFFFFF);
        rom[0] = 32'h001081B3;  // add x3,x1,x1
        rom[1] = 32'h00000000;
        pulse_start();
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) @(negedge clock);
            if (c == 3) begin
                checks++;
                if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL ovf_before_wb: got %b expected 0", ovf_sticky); end
            end
        end
        checks++;
        if ({done, ovf_sticky, pc} !== {1'b1, 1'b1, 4'd1}) begin
            errors++; $display("FAIL ovf_done: done=%b ovf=%b pc=%0d expected 1 1 1", done, ovf_sticky, pc);
        end
        checks++;
        if (rf[3] !== 32'hFFFFFFFE) begin errors++; $display("FAIL ovf_x3: got %0h expected fffffffe", rf[3]); end
        pulse_start();
        checks++;
        if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", ovf_sticky); end
        for (int c = 2; c <= 6; c++) @(negedge clock);
    endtask

    task automatic test_full_length();
        int done_cyc = -1;
        clear_rf();
        for (int i = 0; i < LEN; i++) rom[i] = 32'h00108093;  // addi x1,x1,1
        pulse_start();
        for (int c = 1; c <= 52; c++) begin
            if (c > 1) @(negedge clock);
            if (c == 46) begin
                checks++;
                if (pc !== 4'd15) begin errors++; $display("FAIL full_pc_last: got %0d expected 15", pc); end
            end
            if (done && done_cyc < 0) done_cyc = c;
        end
        checks++;
        if (done_cyc != 49) begin errors++; $display("FAIL full_done_cycle: got %0d expected 49", done_cyc); end
        checks++;
        if ({pc, rf[1]} !== {4'd15, 32'd16}) begin
            errors++; $display("FAIL full_saturate: pc=%0d x1=%0d expected 15 16", pc, rf[1]);
        end
    endtask

    task automatic test_reset_mid_wb();
        clear_rf();
        load_demo();
        pulse_start();
        for (int c = 2; c <= 9; c++) @(negedge clock);
        checks++;
        if ({bus.rf_we, bus.rf_waddr} !== {1'b1, 5'd3}) begin
            errors++; $display("FAIL rst_wb_pre: we=%b wa=%0d expected 1 3", bus.rf_we, bus.rf_waddr);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL rst_wb_we: got %b expected 0", bus.rf_we); end
        @(negedge clock);
        checks++;
        if ({busy, done, err, ovf_sticky, pc, bus.rom_addr, bus.rf_read1, bus.rf_read2, bus.rf_waddr,
             bus.rf_we, bus.alu_ctl, bus.imm_sel, bus.imm, bus.host_ack} !== '0) begin
            errors++; $display("FAIL rst_wb_outputs: busy=%b pc=%0d r1=%0d wa=%0d alu=%0d imm=%0h expected all 0",
                               busy, pc, bus.rf_read1, bus.rf_waddr, bus.alu_ctl, bus.imm);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({rf[1], rf[2], rf[3]} !== {32'd5, 32'd7, 32'd0}) begin
            errors++; $display("FAIL rst_wb_regs: got %0h %0h %0h expected 5 7 0", rf[1], rf[2], rf[3]);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_wb_idle: busy=%b expected 0", busy); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; step_mode = 1'b0; step = 1'b0;
        rf_clr = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_val = '0;
        bus.host_req = 1'b0; bus.host_addr = '0;
        for (int i = 0; i < LEN; i++) rom[i] = 32'h0;
        test_reset();
        test_program();
        test_illegal();
        test_host();
        test_step();
        test_overflow();
        test_full_length();
        test_reset_mid_wb();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
